// File: rtl/rgb_hue_pwm.sv
// rgb_hue_pwm
// Three-channel PWM source whose duties sweep around the hue wheel
// (red -> yellow -> green -> cyan -> blue -> magenta -> red).
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   en             sweep / output enable
//   R_pwm_output   red PWM
//   G_pwm_output   green PWM
//   B_pwm_output   blue PWM
//   phase          current hue phase, 0..5
//   level          current ramp level, 0..MAX
//
// Duties are double-buffered per channel: the target is sampled only while
// the PWM counter sits at MAX, so every period runs on a single duty value.

// ---------------------------------------------------------------------------
// rgb_hue_pwm_ch: one colour channel (active duty register + output compare).
//   clk, rst_n  clock / async reset
//   en_i        output enable (forces output low when 0)
//   cnt_i       shared PWM counter
//   load_i      high in the clock where the counter is MAX
//   tgt_i       target duty for this channel
//   pwm_o       registered PWM output
// ---------------------------------------------------------------------------
module rgb_hue_pwm_ch #(
  parameter int PWM_BITS = 8,
  parameter bit RST_FULL = 1'b0   // reset duty: 1 -> MAX, 0 -> zero
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [PWM_BITS-1:0] cnt_i,
  input  logic                load_i,
  input  logic [PWM_BITS-1:0] tgt_i,
  output logic                pwm_o
);

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q,  pwm_d;

  always_comb begin
    duty_d = load_i ? tgt_i : duty_q;
    // Compare uses the duty already active; a reload only affects the
    // next period because the load clock has cnt=MAX (never < duty).
    pwm_d  = en_i & (cnt_i < duty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= RST_FULL ? '1 : '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// ---------------------------------------------------------------------------
// Top
// ---------------------------------------------------------------------------
module rgb_hue_pwm #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                R_pwm_output,
  output logic                G_pwm_output,
  output logic                B_pwm_output,
  output logic [2:0]          phase,
  output logic [PWM_BITS-1:0] level
);

  localparam int NUM_CH = 3;
  // Keep the prescaler at least one bit wide so STEP_DIV=1 still elaborates.
  localparam int PRE_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);

  logic [PWM_BITS-1:0] cnt_q,   cnt_d;
  logic [PRE_W-1:0]    pre_q,   pre_d;
  logic [2:0]          phase_q, phase_d;
  logic [PWM_BITS-1:0] level_q, level_d;

  logic                             tick;
  logic                             load;
  logic [PWM_BITS-1:0]              inv;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  tgt;   // [0]=R [1]=G [2]=B
  logic [NUM_CH-1:0]                pwm;

  // Counter, prescaler and hue position
  always_comb begin
    cnt_d   = cnt_q + PWM_BITS'(1);      // free-running, wraps MAX->0
    tick    = en && (pre_q == PRE_LAST);
    pre_d   = pre_q;
    phase_d = phase_q;
    level_d = level_q;
    if (en) pre_d = tick ? '0 : pre_q + PRE_W'(1);
    if (tick) begin
      if (level_q == MAX) begin
        level_d = '0;
        phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
      end else begin
        level_d = level_q + PWM_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pre_q   <= '0;
      phase_q <= '0;
      level_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      phase_q <= phase_d;
      level_q <= level_d;
    end
  end

  // Target duty from the registered (pre-tick) phase/level
  always_comb begin
    inv = MAX - level_q;
    tgt = '0;
    case (phase_q)
      3'd0: begin tgt[0] = MAX;     tgt[1] = level_q; tgt[2] = '0;      end
      3'd1: begin tgt[0] = inv;     tgt[1] = MAX;     tgt[2] = '0;      end
      3'd2: begin tgt[0] = '0;      tgt[1] = MAX;     tgt[2] = level_q; end
      3'd3: begin tgt[0] = '0;      tgt[1] = inv;     tgt[2] = MAX;     end
      3'd4: begin tgt[0] = level_q; tgt[1] = '0;      tgt[2] = MAX;     end
      3'd5: begin tgt[0] = MAX;     tgt[1] = '0;      tgt[2] = inv;     end
      default: tgt = '0;
    endcase
  end

  assign load = (cnt_q == MAX);

  // Red resets to full duty so it matches the phase-0/level-0 target.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      rgb_hue_pwm_ch #(
        .PWM_BITS (PWM_BITS),
        .RST_FULL (i == 0)
      ) u_ch (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en),
        .cnt_i  (cnt_q),
        .load_i (load),
        .tgt_i  (tgt[i]),
        .pwm_o  (pwm[i])
      );
    end
  endgenerate

  assign R_pwm_output = pwm[0];
  assign G_pwm_output = pwm[1];
  assign B_pwm_output = pwm[2];
  assign phase        = phase_q;
  assign level        = level_q;

endmodule

// File: tb/tb_rgb_hue_pwm.sv
// Bench for rgb_hue_pwm: three instances (STEP_DIV = 2, 16, 1; PWM_BITS=4)
// share clk/rst_n/en. A model tracks each instance as
// "enabled clocks since reset" -> hue position, and checks all outputs every
// cycle; directed literal expectations pin the model.
module tb_rgb_hue_pwm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic       r_o  [3];
  logic       g_o  [3];
  logic       b_o  [3];
  logic [2:0] ph_o [3];
  logic [3:0] lv_o [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < 3; k++) begin : g_dut
      rgb_hue_pwm #(
        .PWM_BITS (4),
        .STEP_DIV ((k == 0) ? 2 : (k == 1) ? 16 : 1)
      ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .R_pwm_output (r_o[k]),
        .G_pwm_output (g_o[k]),
        .B_pwm_output (b_o[k]),
        .phase        (ph_o[k]),
        .level        (lv_o[k])
      );
    end
  endgenerate

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  function automatic int sd(input int k);
    return (k == 0) ? 2 : (k == 1) ? 16 : 1;
  endfunction

  // Hue table: pos = phase*16 + level
  function automatic int tgt(input int pos, input int c);
    int ph, l;
    int rgb [3];
    ph = pos / 16;
    l  = pos % 16;
    case (ph)
      0:       rgb = '{15, l, 0};
      1:       rgb = '{15 - l, 15, 0};
      2:       rgb = '{0, 15, l};
      3:       rgb = '{0, 15 - l, 15};
      4:       rgb = '{l, 0, 15};
      default: rgb = '{15, 0, 15 - l};
    endcase
    return rgb[c];
  endfunction

  // ---------------- model + per-cycle compare ----------------
  int m_clk  [3];
  int m_en   [3];
  int m_duty [3][3];
  int m_out  [3][3];

  always begin : cmp
    int cb, pb, pa;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_clk[k] = 0;
        m_en[k]  = 0;
        m_duty[k][0] = 15; m_duty[k][1] = 0; m_duty[k][2] = 0;
        for (int c = 0; c < 3; c++) m_out[k][c] = 0;
      end else begin
        cb = m_clk[k] % 16;
        pb = (m_en[k] / sd(k)) % 96;
        for (int c = 0; c < 3; c++)
          m_out[k][c] = (en && cb < m_duty[k][c]) ? 1 : 0;
        if (cb == 15)
          for (int c = 0; c < 3; c++) m_duty[k][c] = tgt(pb, c);
        m_clk[k]++;
        if (en) m_en[k]++;
      end
      pa = (m_en[k] / sd(k)) % 96;
      chk($sformatf("k%0d R", k),     int'(r_o[k]),  m_out[k][0]);
      chk($sformatf("k%0d G", k),     int'(g_o[k]),  m_out[k][1]);
      chk($sformatf("k%0d B", k),     int'(b_o[k]),  m_out[k][2]);
      chk($sformatf("k%0d phase", k), int'(ph_o[k]), pa / 16);
      chk($sformatf("k%0d level", k), int'(lv_o[k]), pa % 16);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int r0c [17], g0c [17], b0c [17], g1c [17], r2c [17], g2c [17];
  int hsum;

  initial begin
    for (int p = 0; p < 17; p++) begin
      r0c[p] = 0; g0c[p] = 0; b0c[p] = 0; g1c[p] = 0; r2c[p] = 0; g2c[p] = 0;
    end

    // 1. reset held for 5 clocks
    repeat (5) tick();
    chk("rst R", int'(r_o[0]), 0);
    chk("rst G", int'(g_o[0]), 0);
    chk("rst B", int'(b_o[0]), 0);
    chk("rst phase", int'(ph_o[0]), 0);
    chk("rst level", int'(lv_o[0]), 0);

    // release with en=1, per-period high counts for 17 periods
    en = 1'b1;
    rst_n = 1'b1;
    for (int e = 1; e <= 272; e++) begin
      int p;
      tick();
      p = (e - 1) / 16;
      r0c[p] += int'(r_o[0]);
      g0c[p] += int'(g_o[0]);
      b0c[p] += int'(b_o[0]);
      g1c[p] += int'(g_o[1]);
      r2c[p] += int'(r_o[2]);
      g2c[p] += int'(g_o[2]);
    end
    chk("p0 R high", r0c[0], 15);
    chk("p0 G high", g0c[0], 0);
    chk("p0 B high", b0c[0], 0);
    // 2. ramp, one step per period; tick coincides with load so lags a period
    chk("ramp p0 G", g1c[0], 0);
    for (int p = 1; p <= 16; p++)
      chk($sformatf("ramp p%0d G", p), g1c[p], p - 1);
    // 6. STEP_DIV=1: loads sample pos 15 then pos 31
    chk("sd1 p1 R", r2c[1], 15);
    chk("sd1 p1 G", g2c[1], 15);
    chk("sd1 p2 R", r2c[2], 0);
    chk("sd1 p2 G", g2c[2], 15);

    // 3. full wrap
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (96) tick();
    chk("half phase", int'(ph_o[0]), 3);
    chk("half level", int'(lv_o[0]), 0);
    repeat (96) tick();
    chk("wrap phase", int'(ph_o[0]), 0);
    chk("wrap level", int'(lv_o[0]), 0);
    chk("wrap sd16 phase", int'(ph_o[1]), 0);
    chk("wrap sd16 level", int'(lv_o[1]), 12);
    chk("wrap sd1 phase", int'(ph_o[2]), 0);
    chk("wrap sd1 level", int'(lv_o[2]), 0);

    // 4. enable gating in phase 2 with prescaler mid-count
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (75) tick();
    chk("gate pre phase", int'(ph_o[0]), 2);
    chk("gate pre level", int'(lv_o[0]), 5);
    en = 1'b0;
    tick();
    hsum = 0;
    for (int k = 0; k < 3; k++) hsum += int'(r_o[k]) + int'(g_o[k]) + int'(b_o[k]);
    chk("gate first clk high", hsum, 0);
    hsum = 0;
    repeat (99) begin
      tick();
      for (int k = 0; k < 3; k++) hsum += int'(r_o[k]) + int'(g_o[k]) + int'(b_o[k]);
    end
    chk("gate high sum", hsum, 0);
    chk("gate hold phase", int'(ph_o[0]), 2);
    chk("gate hold level", int'(lv_o[0]), 5);
    en = 1'b1;
    tick();
    chk("gate resume phase", int'(ph_o[0]), 2);
    chk("gate resume level", int'(lv_o[0]), 6);

    // 5. reset mid-sweep at phase 4, level 7
    repeat (66) tick();
    chk("mid phase", int'(ph_o[0]), 4);
    chk("mid level", int'(lv_o[0]), 7);
    rst_n = 1'b0;
    #1;
    chk("async R", int'(r_o[0]), 0);
    chk("async B", int'(b_o[0]), 0);
    chk("async phase", int'(ph_o[0]), 0);
    chk("async level", int'(lv_o[0]), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    r0c[0] = 0; g0c[0] = 0;
    repeat (16) begin
      tick();
      r0c[0] += int'(r_o[0]);
      g0c[0] += int'(g_o[0]);
    end
    chk("rerst R high", r0c[0], 15);
    chk("rerst G high", g0c[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
